alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Two-port round-robin arbiter and sequencer that shares the single 32-bit ALU between two requesters, such as the main datapath and a multicycle helper unit. It accepts one operation at a time over a valid/ready handshake and drives the ALU control and operand inputs from registers. It captures `ALUResult`/`Zero` into a response register and returns them to the requester that issued the operation. It sits directly in front of the ALU and owns its `ALUOperation`, `A`, `B` and `Shamt` inputs.

## Interface
- `DATA_WIDTH`, default 32: operand/result width.
- `SHAMT_WIDTH`, default 5: shift-amount width.
- `clk`  in  1: the only clock; all state updates on its rising edge.
- `reset`  in  1: asynchronous, active-low.
- `reqN_valid`  in  1: request valid, one per port (N = 0, 1).
- `reqN_ready`  out  1: request accepted this cycle.
- `reqN_op`  in  4: ALU operation code. Codes: AND=0, OR=1, NOR=2, ADD=3, SUB=4, SLL=5, SRL=7, LUI=15.
- `reqN_a`, `reqN_b`  in  DATA_WIDTH: operands.
- `reqN_shamt`  in  SHAMT_WIDTH: shift amount.
- `rspN_valid`  out  1: response available.
- `rspN_ready`  in  1: requester takes the response.
- `rspN_result`  out  DATA_WIDTH: captured ALU result.
- `rspN_zero`  out  1: captured Zero flag.
- `alu_op`  out  4: registered, drives `ALUOperation`.
- `alu_a`, `alu_b`  out  DATA_WIDTH: registered, drive `A`/`B`.
- `alu_shamt`  out  SHAMT_WIDTH: registered, drives `Shamt`.
- `alu_result`  in  DATA_WIDTH: from `ALUResult`.
- `alu_zero`  in  1: from `Zero`.
- `busy`  out  1: state is not IDLE.
- `grant_id`  out  1: port owning the current operation; also the last port served.

## Operation
- **FSM states:** IDLE → EXEC → RESP → IDLE.
- **IDLE:**
  - If any `reqN_valid` is high, pick a winner, assert its `reqN_ready` (combinational on valid and state), latch its op/a/b/shamt into the `alu_*` registers, set `grant_id`, go to EXEC.
  - Only the winner sees ready. The other `reqN_ready` stays 0 and that requester holds its payload stable until accepted.
- **Round-robin:** `last_grant` resets to 1, so port 0 wins the first contention. On simultaneous valids the winner is the port ≠ `last_grant`. A single valid wins regardless. `last_grant` updates to the winner on acceptance.
- **EXEC:** the ALU evaluates combinationally from the registered inputs. At the end of the cycle, `alu_result`/`alu_zero` are captured into the response register. Go to RESP.
- **RESP:**
  - `rspN_valid` is high for port `grant_id` only; `rspN_result`/`rspN_zero` are valid and stable.
  - Stay in RESP while `rspN_ready` is low.
  - On `rspN_valid & rspN_ready`, go to IDLE. No request is accepted in that same cycle.
- **Operation codes:** passed through undecoded. Unlisted codes yield the ALU default result 0 with zero=1; the arbiter returns exactly what the ALU produced.
- **Response outputs of the non-granted port:** `rsp_result`/`rsp_zero` hold the last captured values and are don't-care while `rsp_valid` is 0.
- **Reset (asserted at any time, including mid-EXEC or mid-RESP):**
  - Immediately: state=IDLE, all `rspN_valid`=0, `reqN_ready`=0, `busy`=0, `grant_id`=0, `last_grant`=1.
  - `alu_op`=0, `alu_a`=`alu_b`=0, `alu_shamt`=0; response registers 0.
  - An in-flight operation is discarded with no response.

## Timing
- **Accept to response:** acceptance at cycle T, ALU inputs valid T+1, `rsp_valid` high T+2. Minimum latency is 2 cycles.
- **Throughput:** with `rsp_ready` held high, one operation per 3 cycles. Back-to-back requests from the same port are accepted at T, T+3, T+6, …
- **Backpressure:** each cycle `rsp_ready` stays low adds one cycle; `rsp_*` outputs are unchanged throughout.
- **`busy`:** high from T+1 through the response handshake cycle.

## Test plan
- **Single ADD:** port 0 requests ADD a=5, b=7 at T → `req0_ready`=1 at T; `alu_op`=3 at T+1; `rsp0_valid`=1, result=12, zero=0 at T+2; `rsp1_valid` stays 0.
- **Contention:** both ports valid continuously, SUB 9−9 and OR 1|2, rsp_ready high → grants alternate 0,1,0,1 every 3 cycles. Port 0 gets result=0, zero=1; port 1 gets result=3, zero=0.
- **Backpressure:** port 1 SLL b=1, shamt=4, with `rsp1_ready` low for 4 cycles → `rsp1_valid` held with result=16 for 5 cycles; a new `req0_valid` is not accepted until the cycle after the handshake.
- **LUI and SRL:**
  - LUI b=0x0000ABCD → result 0xABCD0000.
  - SRL b=0x80000000, shamt=31 → result 1.
  - Unlisted code 6 → result 0, zero=1.
- **Reset mid-EXEC:** assert `reset`=0 one cycle after acceptance → outputs go to reset values without waiting for a clock edge; no `rsp_valid` pulse after release. The next contention is won by port 0.
- **Idle ports:** no valids for 20 cycles → `busy`=0, all readies 0, `alu_*` registers unchanged.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - request/response and ALU-side signal bundle for alu_arbiter
interface alu_arbiter_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5
);
  logic                   req0_valid;
  logic                   req0_ready;
  logic [3:0]             req0_op;
  logic [DATA_WIDTH-1:0]  req0_a;
  logic [DATA_WIDTH-1:0]  req0_b;
  logic [SHAMT_WIDTH-1:0] req0_shamt;

  logic                   req1_valid;
  logic                   req1_ready;
  logic [3:0]             req1_op;
  logic [DATA_WIDTH-1:0]  req1_a;
  logic [DATA_WIDTH-1:0]  req1_b;
  logic [SHAMT_WIDTH-1:0] req1_shamt;

  logic                   rsp0_valid;
  logic                   rsp0_ready;
  logic [DATA_WIDTH-1:0]  rsp0_result;
  logic                   rsp0_zero;

  logic                   rsp1_valid;
  logic                   rsp1_ready;
  logic [DATA_WIDTH-1:0]  rsp1_result;
  logic                   rsp1_zero;

  logic [3:0]             alu_op;
  logic [DATA_WIDTH-1:0]  alu_a;
  logic [DATA_WIDTH-1:0]  alu_b;
  logic [SHAMT_WIDTH-1:0] alu_shamt;
  logic [DATA_WIDTH-1:0]  alu_result;
  logic                   alu_zero;

  // Requester side plus the ALU result path.
  modport master (
    output req0_valid, req0_op, req0_a, req0_b, req0_shamt,
    output req1_valid, req1_op, req1_a, req1_b, req1_shamt,
    output rsp0_ready, rsp1_ready,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_result, rsp0_zero,
    input  rsp1_valid, rsp1_result, rsp1_zero,
    input  alu_op, alu_a, alu_b, alu_shamt,
    output alu_result, alu_zero
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b, req0_shamt,
    input  req1_valid, req1_op, req1_a, req1_b, req1_shamt,
    input  rsp0_ready, rsp1_ready,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_result, rsp0_zero,
    output rsp1_valid, rsp1_result, rsp1_zero,
    output alu_op, alu_a, alu_b, alu_shamt,
    input  alu_result, alu_zero
  );

  modport alu (
    input  alu_op, alu_a, alu_b, alu_shamt,
    output alu_result, alu_zero
  );
endinterface

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-port round-robin arbiter sequencing one shared ALU
module alu_arbiter #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic         clk,
  input  logic         reset,
  alu_arbiter_if.slave bus,
  output logic         busy,
  output logic         grant_id
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t                state, state_nxt;
  logic                  last_grant;
  logic                  winner;
  logic                  accept;
  logic                  rsp_hs;
  logic [DATA_WIDTH-1:0] rsp_result;
  logic                  rsp_zero;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Ready is gated by reset so nothing is offered while reset is held low.
  always_comb begin
    state_nxt      = state;
    winner         = (bus.req0_valid && bus.req1_valid) ? ~last_grant : bus.req1_valid;
    accept         = reset && (state == IDLE) && (bus.req0_valid || bus.req1_valid);
    bus.req0_ready = accept && !winner;
    bus.req1_ready = accept && winner;
    bus.rsp0_valid = (state == RESP) && !grant_id;
    bus.rsp1_valid = (state == RESP) && grant_id;
    rsp_hs         = (bus.rsp0_valid && bus.rsp0_ready) || (bus.rsp1_valid && bus.rsp1_ready);
    busy           = (state != IDLE);
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant    <= 1'b1;
      grant_id      <= 1'b0;
      bus.alu_op    <= '0;
      bus.alu_a     <= '0;
      bus.alu_b     <= '0;
      bus.alu_shamt <= '0;
      rsp_result    <= '0;
      rsp_zero      <= 1'b0;
    end else begin
      if (accept) begin
        last_grant    <= winner;
        grant_id      <= winner;
        bus.alu_op    <= winner ? bus.req1_op    : bus.req0_op;
        bus.alu_a     <= winner ? bus.req1_a     : bus.req0_a;
        bus.alu_b     <= winner ? bus.req1_b     : bus.req0_b;
        bus.alu_shamt <= winner ? bus.req1_shamt : bus.req0_shamt;
      end
      // The ALU settles during EXEC from the registered operands.
      if (state == EXEC) begin
        rsp_result <= bus.alu_result;
        rsp_zero   <= bus.alu_zero;
      end
    end
  end

  assign bus.rsp0_result = rsp_result;
  assign bus.rsp0_zero   = rsp_zero;
  assign bus.rsp1_result = rsp_result;
  assign bus.rsp1_zero   = rsp_zero;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter
module tb_alu_arbiter;
  localparam int DW = 32;
  localparam int SW = 5;

  logic clk = 1'b0;
  logic reset;
  logic busy;
  logic grant_id;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  alu_arbiter_if #(.DATA_WIDTH(DW), .SHAMT_WIDTH(SW)) bus ();

  alu_arbiter #(.DATA_WIDTH(DW), .SHAMT_WIDTH(SW)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .busy     (busy),
    .grant_id (grant_id)
  );

  // Reference ALU sitting behind the arbiter.
  always_comb begin
    bus.alu_result = '0;
    case (bus.alu_op)
      4'd0:    bus.alu_result = bus.alu_a & bus.alu_b;
      4'd1:    bus.alu_result = bus.alu_a | bus.alu_b;
      4'd2:    bus.alu_result = ~(bus.alu_a | bus.alu_b);
      4'd3:    bus.alu_result = bus.alu_a + bus.alu_b;
      4'd4:    bus.alu_result = bus.alu_a - bus.alu_b;
      4'd5:    bus.alu_result = bus.alu_b << bus.alu_shamt;
      4'd7:    bus.alu_result = bus.alu_b >> bus.alu_shamt;
      4'd15:   bus.alu_result = {bus.alu_b[15:0], 16'h0000};
      default: bus.alu_result = '0;
    endcase
    bus.alu_zero = (bus.alu_result == '0);
  end

  typedef struct {
    logic        port;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  shamt;
    logic [31:0] exp_res;
    logic        exp_zero;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic p, input logic v, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
    if (!p) begin
      bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b; bus.req0_shamt = sh;
    end else begin
      bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b; bus.req1_shamt = sh;
    end
  endtask

  function automatic logic rdy(input logic p);
    return p ? bus.req1_ready : bus.req0_ready;
  endfunction

  function automatic logic rvld(input logic p);
    return p ? bus.rsp1_valid : bus.rsp0_valid;
  endfunction

  initial begin
    vecs[0] = '{1'b0, 4'd3,  32'd5,      32'd7,          5'd0,  32'd12,         1'b0};
    vecs[1] = '{1'b1, 4'd4,  32'd9,      32'd9,          5'd0,  32'd0,          1'b1};
    vecs[2] = '{1'b0, 4'd1,  32'd1,      32'd2,          5'd0,  32'd3,          1'b0};
    vecs[3] = '{1'b1, 4'd0,  32'hF0F0,   32'h0FF0,       5'd0,  32'h00F0,       1'b0};
    vecs[4] = '{1'b0, 4'd2,  32'd0,      32'd0,          5'd0,  32'hFFFF_FFFF,  1'b0};
    vecs[5] = '{1'b0, 4'd15, 32'd0,      32'h0000_ABCD,  5'd0,  32'hABCD_0000,  1'b0};
    vecs[6] = '{1'b1, 4'd7,  32'd0,      32'h8000_0000,  5'd31, 32'd1,          1'b0};
    vecs[7] = '{1'b0, 4'd6,  32'd12,     32'd34,         5'd3,  32'd0,          1'b1};
    vecs[8] = '{1'b1, 4'd5,  32'd0,      32'd1,          5'd4,  32'd16,         1'b0};
    vecs[9] = '{1'b0, 4'd4,  32'd3,      32'd5,          5'd0,  32'hFFFF_FFFE,  1'b0};

    reset = 1'b0;
    set_req(0, 1'b1, 4'd3, 32'd5, 32'd7, 5'd0);
    set_req(1, 1'b0, 4'd0, 32'd0, 32'd0, 5'd0);
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;
    repeat (3) step();
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_req0_ready", bus.req0_ready, 0);
    chk("rst_rsp_valid", {bus.rsp1_valid, bus.rsp0_valid}, 0);
    chk("rst_alu_op", bus.alu_op, 0);
    chk("rst_alu_a", bus.alu_a, 0);
    chk("rst_rsp_result", bus.rsp0_result, 0);
    set_req(0, 1'b0, 4'd0, 32'd0, 32'd0, 5'd0);
    reset = 1'b1;
    step();

    // Contention: grants alternate starting with port 0.
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;
    set_req(0, 1'b1, 4'd4, 32'd9, 32'd9, 5'd0);
    set_req(1, 1'b1, 4'd1, 32'd1, 32'd2, 5'd0);
    for (int k = 0; k < 4; k++) begin
      logic w;
      w = k[0];
      #1;
      chk($sformatf("cont%0d_ready_win", k), rdy(w), 1);
      chk($sformatf("cont%0d_ready_lose", k), rdy(~w), 0);
      step();
      chk($sformatf("cont%0d_grant", k), grant_id, w);
      chk($sformatf("cont%0d_exec_ready", k), {bus.req1_ready, bus.req0_ready}, 0);
      chk($sformatf("cont%0d_alu_op", k), bus.alu_op, w ? 4'd1 : 4'd4);
      step();
      chk($sformatf("cont%0d_rsp_valid", k), rvld(w), 1);
      chk($sformatf("cont%0d_rsp_other", k), rvld(~w), 0);
      chk($sformatf("cont%0d_result", k), bus.rsp0_result, w ? 32'd3 : 32'd0);
      chk($sformatf("cont%0d_zero", k), bus.rsp0_zero, w ? 1'b0 : 1'b1);
      step();
    end
    set_req(0, 1'b0, 4'd0, 32'd0, 32'd0, 5'd0);
    set_req(1, 1'b0, 4'd0, 32'd0, 32'd0, 5'd0);
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;

    for (int i = 0; i < 10; i++) begin
      logic p;
      p = vecs[i].port;
      set_req(p, 1'b1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].shamt);
      #1;
      chk($sformatf("v%0d_ready", i), rdy(p), 1);
      chk($sformatf("v%0d_ready_other", i), rdy(~p), 0);
      step();
      set_req(p, 1'b0, 4'd0, 32'd0, 32'd0, 5'd0);
      chk($sformatf("v%0d_busy", i), busy, 1);
      chk($sformatf("v%0d_grant", i), grant_id, p);
      chk($sformatf("v%0d_alu_op", i), bus.alu_op, vecs[i].op);
      chk($sformatf("v%0d_alu_b", i), bus.alu_b, vecs[i].b);
      chk($sformatf("v%0d_alu_shamt", i), bus.alu_shamt, vecs[i].shamt);
      step();
      chk($sformatf("v%0d_rsp_valid", i), rvld(p), 1);
      chk($sformatf("v%0d_rsp_other", i), rvld(~p), 0);
      chk($sformatf("v%0d_result", i), p ? bus.rsp1_result : bus.rsp0_result, vecs[i].exp_res);
      chk($sformatf("v%0d_zero", i), p ? bus.rsp1_zero : bus.rsp0_zero, vecs[i].exp_zero);
      if (!p) bus.rsp0_ready = 1'b1; else bus.rsp1_ready = 1'b1;
      step();
      bus.rsp0_ready = 1'b0;
      bus.rsp1_ready = 1'b0;
      chk($sformatf("v%0d_idle", i), busy, 0);
    end

    // Backpressure on port 1 while port 0 waits.
    set_req(1, 1'b1, 4'd5, 32'd0, 32'd1, 5'd4);
    #1;
    chk("bp_req1_ready", bus.req1_ready, 1);
    step();
    set_req(1, 1'b0, 4'd0, 32'd0, 32'd0, 5'd0);
    step();
    set_req(0, 1'b1, 4'd3, 32'd5, 32'd7, 5'd0);
    for (int c = 0; c < 5; c++) begin
      if (c == 4) bus.rsp1_ready = 1'b1;
      #1;
      chk($sformatf("bp%0d_rsp1_valid", c), bus.rsp1_valid, 1);
      chk($sformatf("bp%0d_result", c), bus.rsp1_result, 32'd16);
      chk($sformatf("bp%0d_req0_ready", c), bus.req0_ready, 0);
      chk($sformatf("bp%0d_busy", c), busy, 1);
      step();
    end
    bus.rsp1_ready = 1'b0;
    #1;
    chk("bp_after_rsp1_valid", bus.rsp1_valid, 0);
    chk("bp_after_req0_ready", bus.req0_ready, 1);
    step();
    set_req(0, 1'b0, 4'd0, 32'd0, 32'd0, 5'd0);
    chk("bp_next_alu_op", bus.alu_op, 3);
    step();
    chk("bp_next_result", bus.rsp0_result, 32'd12);
    bus.rsp0_ready = 1'b1;
    step();
    bus.rsp0_ready = 1'b0;

    // Reset while port 0's operation is in EXEC.
    set_req(0, 1'b1, 4'd3, 32'd5, 32'd7, 5'd0);
    #1;
    chk("rx_accept", bus.req0_ready, 1);
    step();
    chk("rx_exec_busy", busy, 1);
    reset = 1'b0;
    #1;
    chk("rx_busy", busy, 0);
    chk("rx_grant", grant_id, 0);
    chk("rx_alu_op", bus.alu_op, 0);
    chk("rx_alu_a", bus.alu_a, 0);
    chk("rx_alu_b", bus.alu_b, 0);
    chk("rx_rsp_valid", {bus.rsp1_valid, bus.rsp0_valid}, 0);
    chk("rx_req0_ready", bus.req0_ready, 0);
    chk("rx_rsp_result", bus.rsp0_result, 0);
    repeat (2) step();
    set_req(0, 1'b0, 4'd0, 32'd0, 32'd0, 5'd0);
    reset = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      chk($sformatf("rx_quiet%0d_rsp", c), {bus.rsp1_valid, bus.rsp0_valid}, 0);
      chk($sformatf("rx_quiet%0d_busy", c), busy, 0);
    end
    set_req(0, 1'b1, 4'd3, 32'd5, 32'd7, 5'd0);
    set_req(1, 1'b1, 4'd1, 32'd1, 32'd2, 5'd0);
    #1;
    chk("rx_cont_req0", bus.req0_ready, 1);
    chk("rx_cont_req1", bus.req1_ready, 0);
    step();
    set_req(0, 1'b0, 4'd0, 32'd0, 32'd0, 5'd0);
    set_req(1, 1'b0, 4'd0, 32'd0, 32'd0, 5'd0);
    chk("rx_cont_grant", grant_id, 0);
    step();
    chk("rx_cont_rsp0", bus.rsp0_valid, 1);
    chk("rx_cont_result", bus.rsp0_result, 32'd12);
    bus.rsp0_ready = 1'b1;
    step();
    bus.rsp0_ready = 1'b0;

    // Idle: ALU registers keep the last accepted operation (ADD 5, 7).
    for (int c = 0; c < 20; c++) begin
      step();
      chk($sformatf("idle%0d_busy", c), busy, 0);
      chk($sformatf("idle%0d_ready", c), {bus.req1_ready, bus.req0_ready}, 0);
      chk($sformatf("idle%0d_rsp", c), {bus.rsp1_valid, bus.rsp0_valid}, 0);
      chk($sformatf("idle%0d_alu_op", c), bus.alu_op, 3);
      chk($sformatf("idle%0d_alu_ab", c), bus.alu_a + (bus.alu_b << 8), 32'd5 + (32'd7 << 8));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
